// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: program counter, req/ack instruction-memory fetch and a
// small prefetch queue feeding IF/ID. Define IF_PREFETCH_EN for a 2-entry queue (full rate).
module if_fetch_stage #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [7:0]  redirect_addr,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruc_out,
  output logic [7:0]  addr_out,
  output logic        valid_out
);

`ifdef IF_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

  logic [7:0]  fetch_pc;
  logic [1:0]  count;
  logic        push;
  logic        pop;
  logic [15:0] head_instr;
  logic [7:0]  head_addr;

  // Request depends only on registered occupancy, never on stall/redirect.
  assign imem_req  = (count < DEPTH_CNT);
  assign imem_addr = fetch_pc;
  assign valid_out = (count != 2'd0);

  // Redirect discards any same-cycle transfer and suppresses the pop.
  assign push = imem_req && imem_ack && !redirect;
  assign pop  = valid_out && !stall && !redirect;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      count    <= 2'd0;
    end else if (redirect) begin
      fetch_pc <= redirect_addr;
      count    <= 2'd0;
    end else begin
      if (push) fetch_pc <= fetch_pc + 8'd1;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef IF_PREFETCH_EN
  logic [15:0] q_instr [DEPTH];
  logic [7:0]  q_addr  [DEPTH];
  logic        rd_ptr;
  logic        wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (redirect) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // NOTE: queue storage is not reset; count gates visibility, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_addr[wr_ptr]  <= fetch_pc;
    end
  end

  assign head_instr = q_instr[rd_ptr];
  assign head_addr  = q_addr[rd_ptr];
`else
  logic [15:0] hold_instr;
  logic [7:0]  hold_addr;

  // Single holding register: pointers collapse to constants.
  always_ff @(posedge clk) begin
    if (push) begin
      hold_instr <= imem_rdata;
      hold_addr  <= fetch_pc;
    end
  end

  assign head_instr = hold_instr;
  assign head_addr  = hold_addr;
`endif

  assign instruc_out = valid_out ? head_instr : 16'h0000;
  assign addr_out    = valid_out ? head_addr  : 8'h00;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage (RESET_PC=8'h10); expectations adapt to IF_PREFETCH_EN.
module tb_if_fetch_stage;

`ifdef IF_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instruc_out;
  logic [7:0]  addr_out;
  logic        valid_out;

  bit   auto_ack;
  logic man_ack;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Memory model: zero-wait (ack = req) or manually acked; data tags the requested address.
  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = {8'hA0, imem_addr};

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(8'h10)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruc_out(instruc_out), .addr_out(addr_out), .valid_out(valid_out)
  );

  // NOTE: inputs change 1 time unit after the rising edge, so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cycles, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (valid_out) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = 8'h00; man_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    auto_ack = 1'b0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = 8'h00; man_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (valid_out !== 1'b0)      $display("FAIL reset_valid: got %b want 0", valid_out); else n_pass++;
    n_checks++; if (instruc_out !== 16'h0)   $display("FAIL reset_instr: got %h want 0000", instruc_out); else n_pass++;
    n_checks++; if (addr_out !== 8'h00)      $display("FAIL reset_addr: got %h want 00", addr_out); else n_pass++;
    n_checks++; if (imem_req !== 1'b1)       $display("FAIL reset_req: got %b want 1", imem_req); else n_pass++;
    n_checks++; if (imem_addr !== 8'h10)     $display("FAIL reset_imem_addr: got %h want 10", imem_addr); else n_pass++;
    rst = 1'b0;
    repeat (3) step();
    n_checks++; if (imem_addr !== 8'h10 || valid_out !== 1'b0)
      $display("FAIL idle_no_ack: got addr %h valid %b want 10/0", imem_addr, valid_out); else n_pass++;
  endtask

  task automatic test_stream();
    logic [7:0] exp;
    auto_ack = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      if (DEPTH == 2 || (i % 2) == 0) begin
        exp = (DEPTH == 2) ? 8'(8'h10 + i) : 8'(8'h10 + i / 2);
        n_checks++; if (valid_out !== 1'b1 || addr_out !== exp || instruc_out !== {8'hA0, exp})
          $display("FAIL stream_%0d: got v=%b a=%h i=%h want v=1 a=%h i=%h", i, valid_out, addr_out, instruc_out, exp, {8'hA0, exp});
        else n_pass++;
      end else begin
        n_checks++; if (valid_out !== 1'b0 || addr_out !== 8'h00 || instruc_out !== 16'h0)
          $display("FAIL stream_gap_%0d: got v=%b a=%h i=%h want 0/00/0000", i, valid_out, addr_out, instruc_out);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    bit found;
    logic [7:0] frozen;
    frozen = (DEPTH == 2) ? 8'h12 : 8'h11;
    auto_ack = 1'b1;
    do_reset();
    step();
    n_checks++; if (valid_out !== 1'b1 || addr_out !== 8'h10)
      $display("FAIL stall_first: got v=%b a=%h want 1/10", valid_out, addr_out); else n_pass++;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (valid_out !== 1'b1 || addr_out !== 8'h10 || instruc_out !== 16'hA010 || imem_req !== 1'b0 || imem_addr !== frozen)
        $display("FAIL stall_hold_%0d: got v=%b a=%h i=%h req=%b ia=%h want 1/10/A010/0/%h",
                 i, valid_out, addr_out, instruc_out, imem_req, imem_addr, frozen);
      else n_pass++;
    end
    stall = 1'b0;
    wait_valid(4, found);
    n_checks++; if (!found || addr_out !== 8'h11 || instruc_out !== 16'hA011)
      $display("FAIL stall_release: got found=%b a=%h i=%h want 11/A011", found, addr_out, instruc_out); else n_pass++;
    wait_valid(4, found);
    n_checks++; if (!found || addr_out !== 8'h12)
      $display("FAIL stall_next: got found=%b a=%h want 12", found, addr_out); else n_pass++;
  endtask

  task automatic test_redirect();
    bit found;
    auto_ack = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (imem_addr == 8'h13 && imem_req) break;
      step();
    end
    n_checks++; if (imem_addr !== 8'h13 || imem_req !== 1'b1)
      $display("FAIL redir_setup: got ia=%h req=%b want 13/1", imem_addr, imem_req); else n_pass++;
    redirect = 1'b1; redirect_addr = 8'h40;
    step();
    redirect = 1'b0;
    n_checks++; if (valid_out !== 1'b0 || addr_out !== 8'h00 || imem_addr !== 8'h40)
      $display("FAIL redir_flush: got v=%b a=%h ia=%h want 0/00/40", valid_out, addr_out, imem_addr); else n_pass++;
    step();
    n_checks++; if (valid_out !== 1'b1 || addr_out !== 8'h40 || instruc_out !== 16'hA040)
      $display("FAIL redir_target: got v=%b a=%h i=%h want 1/40/A040", valid_out, addr_out, instruc_out); else n_pass++;
    wait_valid(4, found);
    n_checks++; if (!found || addr_out !== 8'h41)
      $display("FAIL redir_follow: got found=%b a=%h want 41", found, addr_out); else n_pass++;
  endtask

  task automatic test_back_to_back_redirect();
    auto_ack = 1'b1;
    do_reset();
    redirect = 1'b1; redirect_addr = 8'h20;
    step();
    redirect_addr = 8'h30;
    step();
    redirect = 1'b0;
    n_checks++; if (valid_out !== 1'b0 || imem_addr !== 8'h30)
      $display("FAIL b2b_redir: got v=%b ia=%h want 0/30", valid_out, imem_addr); else n_pass++;
    step();
    n_checks++; if (valid_out !== 1'b1 || addr_out !== 8'h30)
      $display("FAIL b2b_target: got v=%b a=%h want 1/30", valid_out, addr_out); else n_pass++;
  endtask

  task automatic test_latency();
    auto_ack = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (imem_addr !== 8'h10 || valid_out !== 1'b0 || imem_req !== 1'b1)
        $display("FAIL lat_wait1_%0d: got ia=%h v=%b req=%b want 10/0/1", i, imem_addr, valid_out, imem_req); else n_pass++;
    end
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    n_checks++; if (valid_out !== 1'b1 || addr_out !== 8'h10 || instruc_out !== 16'hA010)
      $display("FAIL lat_first: got v=%b a=%h i=%h want 1/10/A010", valid_out, addr_out, instruc_out); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (imem_addr !== 8'h11 || valid_out !== 1'b0 || imem_req !== 1'b1)
        $display("FAIL lat_wait2_%0d: got ia=%h v=%b req=%b want 11/0/1", i, imem_addr, valid_out, imem_req); else n_pass++;
    end
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    n_checks++; if (valid_out !== 1'b1 || addr_out !== 8'h11 || instruc_out !== 16'hA011)
      $display("FAIL lat_second: got v=%b a=%h i=%h want 1/11/A011", valid_out, addr_out, instruc_out); else n_pass++;
  endtask

  task automatic test_wrap();
    bit found;
    logic [7:0] exp;
    auto_ack = 1'b1;
    do_reset();
    redirect = 1'b1; redirect_addr = 8'hFE;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp = 8'hFE + 8'(k);
      wait_valid(4, found);
      n_checks++; if (!found || addr_out !== exp || instruc_out !== {8'hA0, exp})
        $display("FAIL wrap_%0d: got found=%b a=%h i=%h want %h", k, found, addr_out, instruc_out, exp); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    bit found;
    auto_ack = 1'b1;
    do_reset();
    stall = 1'b1;
    repeat (4) step();
    n_checks++; if (valid_out !== 1'b1 || imem_req !== 1'b0)
      $display("FAIL areset_full: got v=%b req=%b want 1/0", valid_out, imem_req); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (valid_out !== 1'b0 || instruc_out !== 16'h0 || addr_out !== 8'h00 || imem_req !== 1'b1 || imem_addr !== 8'h10)
      $display("FAIL areset_async: got v=%b i=%h a=%h req=%b ia=%h want 0/0000/00/1/10",
               valid_out, instruc_out, addr_out, imem_req, imem_addr);
    else n_pass++;
    step();
    rst = 1'b0;
    stall = 1'b0;
    wait_valid(4, found);
    n_checks++; if (!found || addr_out !== 8'h10 || instruc_out !== 16'hA010)
      $display("FAIL areset_restart: got found=%b a=%h i=%h want 10/A010", found, addr_out, instruc_out); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;
    man_ack = 1'b0; auto_ack = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back_redirect();
    test_latency();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction fetch stage feeding the IF/ID pipeline buffer. Holds the 8-bit program counter, issues word fetches to instruction memory over a req/ack handshake, and queues fetched 16-bit instructions with their addresses in a small prefetch queue. The queue head is presented to IF/ID as `instruc_out`/`addr_out`. Decode/execute can stall consumption or redirect fetch on a taken branch or jump.

## Interface
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: downstream not ready; head entry must not be consumed.
- `redirect` in 1: taken branch/jump; flush and refetch.
- `redirect_addr` in 8: new fetch address when `redirect`=1.
- `imem_req` out 1: fetch request.
- `imem_addr` out 8: word address of the request (current fetch PC).
- `imem_ack` in 1: memory returns `imem_rdata` for `imem_addr` this cycle.
- `imem_rdata` in 16: instruction word.
- `instruc_out` out 16: head instruction to IF/ID; 16'h0000 when invalid.
- `addr_out` out 8: address of head instruction; 8'h00 when invalid.
- `valid_out` out 1: head entry valid.

## Operation
- Queue depth DEPTH = 2 with `IF_PREFETCH_EN`, else 1. Each entry holds {instr[15:0], addr[7:0]}. Circular read/write pointers plus a registered count (0..DEPTH).
- `imem_req` = (count < DEPTH). Depends on registered state only; not gated by `stall` or `redirect`.
- `imem_addr` = fetch_pc (registered).
- Transfer: a cycle with `imem_req` && `imem_ack`. Data corresponds to that cycle's `imem_addr`. Memory may take any number of cycles. Only the address present in the ack cycle matters; `imem_addr` may change before ack (after a redirect).
- On a transfer without redirect: push {`imem_rdata`, fetch_pc} and set fetch_pc <= fetch_pc + 1. 8'hFF wraps to 8'h00.
- Pop: `valid_out` && !`stall` && !`redirect`; advances the read pointer.
- Push and pop in the same cycle: both occur, count unchanged.
- Redirect (highest priority): flush the queue (count <= 0, pointers <= 0) and set fetch_pc <= `redirect_addr`. A transfer in the same cycle is discarded and no pop occurs. `stall` is ignored.
- Outputs are combinational from the head entry, masked to zero when count = 0.
- Reset: fetch_pc = `RESET_PC`, count = 0, pointers = 0.
  - Outputs: `valid_out`=0, `instruc_out`=16'h0000, `addr_out`=8'h00, `imem_req`=1, `imem_addr`=`RESET_PC`.
  - Reset mid-fetch drops the outstanding request and all queued entries.

## Timing
- Fetch latency: ack in cycle N gives `valid_out`=1 with that word in cycle N+1.
- Depth 2 with a zero-wait memory (ack = req): one instruction per cycle while `stall`=0.
- Depth 1: at most one instruction every 2 cycles. `imem_req` drops the cycle after a push and rises the cycle after the pop.
- Redirect asserted in cycle N:
  - `valid_out`=0 in N+1.
  - `imem_addr`=`redirect_addr` in N+1.
  - First redirected instruction is valid in N+2 if ack arrives in N+1.
- Full queue with `stall`=1: `imem_req`=0, fetch_pc holds, head holds stable indefinitely.
- Back-to-back redirects: the latest one wins; each flushes.

## Configuration
- `IF_PREFETCH_EN` defined: DEPTH=2 prefetch queue, full-rate fetch.
- `IF_PREFETCH_EN` undefined: DEPTH=1, a single holding register. The pointers reduce to constants, and the same handshake and redirect rules apply at half throughput.

## Test plan
- Reset, `RESET_PC`=8'h10, zero-wait memory returning {8'hA0, addr}, `stall`=0 -> `addr_out` sequence 10,11,12… one per cycle (`IF_PREFETCH_EN`) or every other cycle (no macro); `instruc_out`=16'hA010, 16'hA011, …
- Hold `stall`=1 for 5 cycles after the first valid -> head stays 8'h10/16'hA010, queue fills to DEPTH, `imem_req`=0, `imem_addr` frozen at 8'h12 (depth 2). Release -> 8'h11 follows with none lost or duplicated.
- `redirect`=1 with `redirect_addr`=8'h40 in a cycle that also has an ack for 8'h13 -> 8'h13 never appears, `valid_out`=0 next cycle, then `addr_out`=8'h40.
- Memory with 3-cycle ack latency -> `imem_addr` held until ack; `valid_out` rises exactly 1 cycle after each ack.
- Start at PC 8'hFE -> `addr_out` sequence FE, FF, 00, 01.
- Assert `rst` mid-stall with a full queue -> all outputs return to reset values immediately, asynchronously and without a clock edge; after release, fetch restarts at `RESET_PC`.
